// File: rtl/switch_led_ctrl.sv
// switch_led_ctrl: N-channel push-button front end (synchronise, debounce,
// press pulse) feeding a mode-selected LED driver: direct, toggle, blink or
// press counter. All state sits behind one async active-low reset.
module switch_led_ctrl #(
    parameter int NUM_CH            = 4,
    parameter int DEBOUNCE_CYCLES   = 250000,
    parameter int BLINK_HALF_CYCLES = 6250000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NUM_CH-1:0] i_switch,
    input  logic [1:0]        i_mode,
    input  logic              i_clear,
    output logic [NUM_CH-1:0] o_press,
    output logic [NUM_CH-1:0] o_led
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int BLK_W = $clog2(BLINK_HALF_CYCLES + 1);

    // Last count value before the debounced state is allowed to change.
    localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    // Last blink timer value before the phase flips.
    localparam logic [BLK_W-1:0] BLK_LAST = BLK_W'(BLINK_HALF_CYCLES - 1);

    localparam logic [1:0] MODE_DIRECT = 2'b00;
    localparam logic [1:0] MODE_TOGGLE = 2'b01;
    localparam logic [1:0] MODE_BLINK  = 2'b10;
    localparam logic [1:0] MODE_COUNT  = 2'b11;

    logic [NUM_CH-1:0] sync1_r;
    logic [NUM_CH-1:0] sw_s;
    logic [NUM_CH-1:0] stable_r;
    logic [CNT_W-1:0]  cnt_r [NUM_CH];
    logic [NUM_CH-1:0] tog_r;
    logic [NUM_CH-1:0] pcnt_r;
    logic [BLK_W-1:0]  blink_cnt_r;
    logic              phase_r;

    logic [NUM_CH-1:0] stable_nxt_s;
    logic [CNT_W-1:0]  cnt_nxt_s [NUM_CH];
    logic [NUM_CH-1:0] press_s;
    logic [NUM_CH-1:0] led_nxt_s;

    // Two-flop synchroniser for the asynchronous switch pins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_r <= '0;
            sw_s    <= '0;
        end else begin
            sync1_r <= i_switch;
            sw_s    <= sync1_r;
        end
    end

    // Debounce: count consecutive disagreeing samples, adopt the new level on the last one.
    always_comb begin
        stable_nxt_s = stable_r;
        for (int i = 0; i < NUM_CH; i++) begin
            cnt_nxt_s[i] = '0;
            if (sw_s[i] == stable_r[i]) begin
                cnt_nxt_s[i] = '0;
            end else if (cnt_r[i] == DEB_LAST) begin
                stable_nxt_s[i] = sw_s[i];
                cnt_nxt_s[i]    = '0;
            end else begin
                cnt_nxt_s[i] = cnt_r[i] + CNT_W'(1);
            end
        end
        press_s = stable_nxt_s & ~stable_r;
    end

    // Debounced state, per-channel counters and the press pulse register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stable_r <= '0;
            o_press  <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                cnt_r[i] <= '0;
            end
        end else begin
            stable_r <= stable_nxt_s;
            o_press  <= press_s;
            for (int i = 0; i < NUM_CH; i++) begin
                cnt_r[i] <= cnt_nxt_s[i];
            end
        end
    end

    // Toggle bits and channel-0 press counter; clear beats a coincident press.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tog_r  <= '0;
            pcnt_r <= '0;
        end else if (i_clear) begin
            tog_r  <= '0;
            pcnt_r <= '0;
        end else begin
            tog_r  <= tog_r ^ press_s;
            pcnt_r <= pcnt_r + NUM_CH'(press_s[0]);
        end
    end

    // Free-running blink timer; only reset restarts it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            blink_cnt_r <= '0;
            phase_r     <= 1'b0;
        end else if (blink_cnt_r == BLK_LAST) begin
            blink_cnt_r <= '0;
            phase_r     <= ~phase_r;
        end else begin
            blink_cnt_r <= blink_cnt_r + BLK_W'(1);
            phase_r     <= phase_r;
        end
    end

    // LED source selection from the current registered state.
    always_comb begin
        led_nxt_s = '0;
        case (i_mode)
            MODE_DIRECT: led_nxt_s = stable_r;
            MODE_TOGGLE: led_nxt_s = tog_r;
            MODE_BLINK:  led_nxt_s = stable_r & {NUM_CH{phase_r}};
            MODE_COUNT:  led_nxt_s = pcnt_r;
            default:     led_nxt_s = stable_r;
        endcase
    end

    // Registered LED drive.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_led <= '0;
        end else begin
            o_led <= led_nxt_s;
        end
    end

endmodule

// File: tb/tb_switch_led_ctrl.sv
// Testbench for switch_led_ctrl: a directed vector table, hand-written corner
// sequences and random stimulus, all checked against an event-level model.
module tb_switch_led_ctrl;

    localparam int NCH = 4;
    localparam int DEB = 4;
    localparam int BH  = 3;

    logic           clk;
    logic           rst_n;
    logic [NCH-1:0] switch_in;
    logic [1:0]     mode_in;
    logic           clear_in;
    logic [NCH-1:0] o_press;
    logic [NCH-1:0] o_led;

    int n_cmp;
    int n_bad;

    // Reference model state
    logic [NCH-1:0] m_stable;
    logic [NCH-1:0] m_hist [DEB];
    logic [NCH-1:0] m_p1;
    logic [NCH-1:0] m_p2;
    int             m_tog [NCH];
    int             m_pcnt;
    int             m_edges;
    logic [NCH-1:0] exp_press;
    logic [NCH-1:0] exp_led;

    typedef struct {
        logic [NCH-1:0] sw;
        logic [1:0]     mode;
        logic           clr;
        logic [NCH-1:0] press;
        logic [NCH-1:0] led;
    } vec_t;

    vec_t vecs [16];

    switch_led_ctrl #(
        .NUM_CH(NCH),
        .DEBOUNCE_CYCLES(DEB),
        .BLINK_HALF_CYCLES(BH)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .i_switch(switch_in),
        .i_mode(mode_in),
        .i_clear(clear_in),
        .o_press(o_press),
        .o_led(o_led)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [NCH-1:0] act, input logic [NCH-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_stable = '0;
        m_p1     = '0;
        m_p2     = '0;
        m_pcnt   = 0;
        m_edges  = 0;
        for (int i = 0; i < DEB; i++) m_hist[i] = '0;
        for (int c = 0; c < NCH; c++) m_tog[c] = 0;
    endtask

    // One clock edge of the model: pin seen by the debouncer is two edges old;
    // a channel flips once its last DEB samples all disagree with it.
    task automatic model_edge(input logic [NCH-1:0] pin, input logic [1:0] mode, input logic clr);
        logic [NCH-1:0] new_stable;
        logic [NCH-1:0] tog_bits;
        logic           phase;
        bit             all_diff;
        for (int i = DEB - 1; i > 0; i--) m_hist[i] = m_hist[i-1];
        m_hist[0] = m_p2;
        new_stable = m_stable;
        for (int c = 0; c < NCH; c++) begin
            all_diff = 1'b1;
            for (int i = 0; i < DEB; i++) begin
                if (m_hist[i][c] == m_stable[c]) all_diff = 1'b0;
            end
            if (all_diff) new_stable[c] = ~m_stable[c];
        end
        exp_press = new_stable & ~m_stable;
        phase = ((m_edges / BH) % 2) == 1;
        for (int c = 0; c < NCH; c++) tog_bits[c] = (m_tog[c] % 2) == 1;
        case (mode)
            2'b00:   exp_led = m_stable;
            2'b01:   exp_led = tog_bits;
            2'b10:   exp_led = phase ? m_stable : 4'b0000;
            default: exp_led = NCH'(m_pcnt);
        endcase
        m_stable = new_stable;
        if (clr) begin
            m_pcnt = 0;
            for (int c = 0; c < NCH; c++) m_tog[c] = 0;
        end else begin
            for (int c = 0; c < NCH; c++) m_tog[c] += int'(exp_press[c]);
            m_pcnt = (m_pcnt + int'(exp_press[0])) % 16;
        end
        m_edges++;
        m_p2 = m_p1;
        m_p1 = pin;
    endtask

    // Drive inputs at the negedge, step model and DUT one edge, compare at next negedge.
    task automatic tick(input logic [NCH-1:0] sw, input logic [1:0] mode, input logic clr);
        switch_in = sw;
        mode_in   = mode;
        clear_in  = clr;
        model_edge(sw, mode, clr);
        @(posedge clk);
        @(negedge clk);
        check("model_press", o_press, exp_press);
        check("model_led", o_led, exp_led);
    endtask

    task automatic press_ch(input logic [NCH-1:0] mask, input logic [1:0] mode);
        for (int k = 0; k < 8; k++) tick(mask, mode, 1'b0);
        for (int k = 0; k < 8; k++) tick(4'b0000, mode, 1'b0);
    endtask

    // Assert reset mid-cycle, check outputs clear immediately and while held, release at negedge.
    task automatic async_reset();
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_async_led", o_led, 4'b0000);
        check("rst_async_press", o_press, 4'b0000);
        switch_in = 4'b1111;
        clear_in  = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("rst_hold_led", o_led, 4'b0000);
            check("rst_hold_press", o_press, 4'b0000);
        end
        switch_in = 4'b0000;
        rst_n = 1'b1;
        model_reset();
    endtask

    initial begin
        int ones;
        int hold;
        logic [NCH-1:0] rsw;
        logic [1:0]     rmode;

        n_cmp = 0;
        n_bad = 0;

        // DIRECT table: sw[0] rises at row 0, pulse on row 5, LED on row 6;
        // 3-cycle glitch on sw[1] in rows 8..10 must leave everything unchanged.
        for (int r = 0; r < 16; r++) begin
            vecs[r].sw    = 4'b0001;
            vecs[r].mode  = 2'b00;
            vecs[r].clr   = 1'b0;
            vecs[r].press = 4'b0000;
            vecs[r].led   = (r >= 6) ? 4'b0001 : 4'b0000;
        end
        vecs[5].press = 4'b0001;
        vecs[8].sw  = 4'b0011;
        vecs[9].sw  = 4'b0011;
        vecs[10].sw = 4'b0011;

        rst_n     = 1'b0;
        switch_in = '0;
        mode_in   = 2'b00;
        clear_in  = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        check("reset_led", o_led, 4'b0000);
        check("reset_press", o_press, 4'b0000);
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) tick(4'b0000, 2'b00, 1'b0);
        check("post_release_led", o_led, 4'b0000);
        model_reset();
        async_reset();

        for (int r = 0; r < 16; r++) begin
            tick(vecs[r].sw, vecs[r].mode, vecs[r].clr);
            check($sformatf("vec%0d_press", r), o_press, vecs[r].press);
            check($sformatf("vec%0d_led", r), o_led, vecs[r].led);
        end

        // Async reset with LED lit, then reset in the middle of a debounce.
        async_reset();
        for (int k = 0; k < 3; k++) tick(4'b0010, 2'b00, 1'b0);
        async_reset();
        ones = 0;
        for (int k = 0; k < 10; k++) begin
            tick(4'b0000, 2'b00, 1'b0);
            if (o_press != 4'b0000) ones++;
        end
        check("mid_deb_reset_led", o_led, 4'b0000);
        check("mid_deb_reset_pulses", NCH'(ones), 4'b0000);

        // TOGGLE
        tick(4'b0000, 2'b01, 1'b1);
        for (int k = 0; k < 3; k++) press_ch(4'b0100, 2'b01);
        check("toggle_3press", o_led, 4'b0100);
        tick(4'b0000, 2'b01, 1'b1);
        tick(4'b0000, 2'b01, 1'b0);
        check("toggle_clear", o_led, 4'b0000);
        for (int k = 0; k < 5; k++) tick(4'b0100, 2'b01, 1'b0);
        tick(4'b0100, 2'b01, 1'b1);
        check("clr_press_pulse", o_press, 4'b0100);
        for (int k = 0; k < 2; k++) tick(4'b0100, 2'b01, 1'b0);
        check("clr_press_led", o_led, 4'b0000);
        for (int k = 0; k < 8; k++) tick(4'b0000, 2'b01, 1'b0);

        // COUNT
        tick(4'b0000, 2'b11, 1'b1);
        for (int k = 0; k < 17; k++) press_ch(4'b0001, 2'b11);
        check("count_wrap", o_led, 4'b0001);
        for (int k = 0; k < 5; k++) tick(4'b1111, 2'b11, 1'b0);
        tick(4'b1111, 2'b11, 1'b0);
        check("count_all_pulse", o_press, 4'b1111);
        for (int k = 0; k < 2; k++) tick(4'b1111, 2'b11, 1'b0);
        for (int k = 0; k < 8; k++) tick(4'b0000, 2'b11, 1'b0);
        check("count_all_inc", o_led, 4'b0010);

        // BLINK
        ones = 0;
        for (int k = 0; k < 20; k++) begin
            tick(4'b1000, 2'b10, 1'b0);
            if (k >= 8 && o_led[3]) ones++;
        end
        check("blink_duty", NCH'(ones), 4'd6);
        for (int k = 0; k < 10; k++) tick(4'b0000, 2'b10, 1'b0);
        check("blink_release", o_led, 4'b0000);

        // Mode switching keeps the count
        tick(4'b0000, 2'b11, 1'b1);
        for (int k = 0; k < 2; k++) press_ch(4'b0001, 2'b11);
        for (int k = 0; k < 3; k++) press_ch(4'b0001, 2'b01);
        tick(4'b0000, 2'b11, 1'b0);
        check("mode_switch_count", o_led, 4'b0101);

        // Random stimulus against the model
        rmode = 2'b00;
        for (int s = 0; s < 300; s++) begin
            rsw  = NCH'($urandom_range(0, 15));
            hold = $urandom_range(1, 8);
            if ($urandom_range(0, 9) == 0) rmode = 2'($urandom_range(0, 3));
            for (int k = 0; k < hold; k++) begin
                tick(rsw, rmode, ($urandom_range(0, 39) == 0) ? 1'b1 : 1'b0);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
